drp_resp: RTL and testbench

DRP_RESP -- requirements
Module: drp_resp

---
 rtl/drp_resp.sv | 181 ++++++++++++++++++
 tb/tb_drp_resp.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drp_resp.sv
// drp_resp: behavioural DRP responder with a modelled PLL lock indicator.
//
// A DEN strobe starts a transaction. DWE, DADDR and DI are captured when the
// strobe is accepted, and DRDY pulses for one cycle LAT cycles later. A write
// updates the 32 x 16-bit register file on the edge that raises DRDY. A read
// returns the addressed register on DO during its DRDY cycle. A DEN that
// arrives while a transaction is pending, outside its DRDY cycle, is dropped
// and sets the sticky PROT_ERR flag.
//
// LOCKED asserts after LOCK_CYC consecutive cycles with RST_PLL low.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   DEN      in   transaction strobe
//   DWE      in   write qualifier, sampled with DEN
//   DADDR    in   [4:0] register address, sampled with DEN
//   DI       in   [15:0] write data, sampled with DEN
//   DO       out  [15:0] read data, zero unless a read DRDY cycle
//   DRDY     out  one-cycle completion pulse
//   RST_PLL  in   modelled PLL reset, active-high
//   LOCKED   out  modelled PLL lock
//   PROT_ERR out  sticky protocol-violation flag
module drp_resp #(
  parameter int unsigned LAT      = 4,
  parameter int unsigned LOCK_CYC = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DEN,
  input  logic        DWE,
  input  logic [4:0]  DADDR,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  output logic        DRDY,
  input  logic        RST_PLL,
  output logic        LOCKED,
  output logic        PROT_ERR
);

  localparam int unsigned CntW  = $clog2(LAT + 1);
  localparam int unsigned LockW = $clog2(LOCK_CYC + 1);
  localparam logic [CntW-1:0]  LatVal  = CntW'(LAT);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_CYC);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  cnt_inc;
  logic             drdy_q, drdy_d;
  logic             we_q, we_d;
  logic [4:0]       addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic             perr_q, perr_d;
  logic             accept;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [15:0]      wr_data;
  logic [15:0]      mem_q [32];
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;

  assign cnt_inc = cnt_q + 1'b1;

  // Transaction sequencing. cnt_q counts edges since acceptance, the
  // accepting edge being 1, so DRDY is raised on the edge where it hits LAT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drdy_d  = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    perr_d  = perr_q;
    accept  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = addr_q;
    wr_data = data_q;

    unique case (state_q)
      StIdle: accept = DEN;
      StBusy: begin
        if (drdy_q) begin
          // The DRDY cycle may start the next transaction with no gap.
          accept = DEN;
          if (!DEN) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          if (DEN) begin
            perr_d = 1'b1;
          end
          cnt_d = cnt_inc;
          if (cnt_inc == LatVal) begin
            drdy_d = 1'b1;
            wr_en  = we_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = StBusy;
      cnt_d   = CntW'(1);
      we_d    = DWE;
      addr_d  = DADDR;
      data_d  = DI;
      // With LAT=1 the accepting edge is also the DRDY edge, so the write
      // must use the live inputs being captured on this same edge.
      if (LAT == 1) begin
        drdy_d  = 1'b1;
        wr_en   = DWE;
        wr_addr = DADDR;
        wr_data = DI;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drdy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drdy_q  <= drdy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Lock counter saturates at LOCK_CYC, so LOCKED holds until RST_PLL.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = 1'b0;
    if (RST_PLL) begin
      lock_cnt_d = '0;
    end else begin
      if (lock_cnt_q != LockMax) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
      locked_d = (lock_cnt_d == LockMax);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign DO       = (drdy_q && !we_q) ? mem_q[addr_q] : 16'h0000;
  assign DRDY     = drdy_q;
  assign LOCKED   = locked_q;
  assign PROT_ERR = perr_q;

endmodule

// File: tb/tb_drp_resp.sv
// Bench for drp_resp. Instance 0 uses LAT=4, LOCK_CYC=64; instance 1 uses
// LAT=1, LOCK_CYC=3. A transaction-level model (pending transaction with a
// due cycle, an array for the register file, a low-cycle count for lock)
// gives the expected outputs for every cycle.
module tb_drp_resp;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        den0 = 1'b0, dwe0 = 1'b0, pll0 = 1'b0;
  logic        den1 = 1'b0, dwe1 = 1'b0, pll1 = 1'b0;
  logic [4:0]  daddr0 = '0, daddr1 = '0;
  logic [15:0] di0 = '0, di1 = '0;
  logic [15:0] do0, do1;
  logic        drdy0, drdy1, locked0, locked1, perr0, perr1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int lat_of  [2] = '{4, 1};
  int lock_of [2] = '{64, 3};

  // Stimulus for the current cycle, applied by step().
  bit          i_den [2];
  bit          i_dwe [2];
  logic [4:0]  i_addr [2];
  logic [15:0] i_di [2];
  bit          i_pll [2];

  // Reference model state and expectations for the current cycle.
  bit          m_busy [2];
  int          m_due [2];
  bit          m_we [2];
  logic [4:0]  m_addr [2];
  logic [15:0] m_data [2];
  logic [15:0] m_mem [2][32];
  bit          m_prot [2];
  int          m_low [2];
  bit          m_locked [2];
  bit          exp_drdy [2];
  logic [15:0] exp_do [2];

  drp_resp #(.LAT(4), .LOCK_CYC(64)) u_dut0 (
    .CLK(CLK), .RST(RST), .DEN(den0), .DWE(dwe0), .DADDR(daddr0), .DI(di0),
    .DO(do0), .DRDY(drdy0), .RST_PLL(pll0), .LOCKED(locked0), .PROT_ERR(perr0)
  );

  drp_resp #(.LAT(1), .LOCK_CYC(3)) u_dut1 (
    .CLK(CLK), .RST(RST), .DEN(den1), .DWE(dwe1), .DADDR(daddr1), .DI(di1),
    .DO(do1), .DRDY(drdy1), .RST_PLL(pll1), .LOCKED(locked1), .PROT_ERR(perr1)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_due[k] = 0; m_we[k] = 0; m_addr[k] = '0; m_data[k] = '0;
      m_prot[k] = 0; m_low[k] = 0; m_locked[k] = 0;
      exp_drdy[k] = 0; exp_do[k] = '0;
      i_den[k] = 0; i_dwe[k] = 0; i_addr[k] = '0; i_di[k] = '0;
      for (int a = 0; a < 32; a++) m_mem[k][a] = '0;
    end
  endtask

  // Called at a negedge: drives this cycle's inputs, advances the model past
  // the coming rising edge, and waits for the next negedge.
  task automatic step();
    den0 = i_den[0]; dwe0 = i_dwe[0]; daddr0 = i_addr[0]; di0 = i_di[0]; pll0 = i_pll[0];
    den1 = i_den[1]; dwe1 = i_dwe[1]; daddr1 = i_addr[1]; di1 = i_di[1]; pll1 = i_pll[1];
    for (int k = 0; k < 2; k++) begin
      bit acc;
      acc = i_den[k] && (!m_busy[k] || exp_drdy[k]);
      if (acc) begin
        m_busy[k] = 1; m_due[k] = cyc + lat_of[k];
        m_we[k] = i_dwe[k]; m_addr[k] = i_addr[k]; m_data[k] = i_di[k];
      end else begin
        if (i_den[k]) m_prot[k] = 1;
        if (exp_drdy[k]) m_busy[k] = 0;
      end
      if (i_pll[k]) m_low[k] = 0;
      else if (m_low[k] < lock_of[k]) m_low[k]++;
      m_locked[k] = (m_low[k] == lock_of[k]);
      i_den[k] = 0;
    end
    @(negedge CLK);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      exp_drdy[k] = m_busy[k] && (m_due[k] == cyc);
      if (exp_drdy[k] && m_we[k]) m_mem[k][m_addr[k]] = m_data[k];
      exp_do[k] = (exp_drdy[k] && !m_we[k]) ? m_mem[k][m_addr[k]] : 16'h0000;
    end
  endtask

  task automatic test_reset();
    model_reset();
    for (int k = 0; k < 2; k++) i_pll[k] = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      total++;
      if ({drdy0, do0, locked0, perr0, drdy1, do1, locked1, perr1} !== '0) begin
        bad++;
        $display("FAIL reset n=%0d got d0=%b/%h/%b/%b d1=%b/%h/%b/%b want all zero", n,
                 drdy0, do0, locked0, perr0, drdy1, do1, locked1, perr1);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_write_read();
    for (int n = 0; n <= 8; n++) begin
      bit          want_drdy;
      logic [15:0] want_do;
      want_drdy = (n == 4) || (n == 8);
      want_do   = (n == 8) ? 16'h1234 : 16'h0000;
      total++;
      if (drdy0 !== want_drdy || do0 !== want_do || perr0 !== 1'b0) begin
        bad++;
        $display("FAIL wr_rd n=%0d got drdy=%b do=%h perr=%b want drdy=%b do=%h perr=0",
                 n, drdy0, do0, perr0, want_drdy, want_do);
      end
      if (n == 0) begin
        i_den[0] = 1; i_dwe[0] = 1; i_addr[0] = 5'h08; i_di[0] = 16'h1234;
      end else if (n == 4) begin
        i_den[0] = 1; i_dwe[0] = 0; i_addr[0] = 5'h08; i_di[0] = 16'hFFFF;
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n <= 5; n++) begin
      bit          want_drdy;
      logic [15:0] want_do;
      want_drdy = (n >= 1) && (n <= 4);
      want_do   = (n == 2 || n == 4) ? 16'hA5A5 : 16'h0000;
      total++;
      if (drdy1 !== want_drdy || do1 !== want_do || perr1 !== 1'b0) begin
        bad++;
        $display("FAIL b2b n=%0d got drdy=%b do=%h perr=%b want drdy=%b do=%h perr=0",
                 n, drdy1, do1, perr1, want_drdy, want_do);
      end
      if (n <= 3) begin
        i_den[1] = 1; i_dwe[1] = (n % 2 == 0); i_addr[1] = 5'h1F;
        i_di[1] = (n % 2 == 0) ? 16'hA5A5 : 16'h0F0F;
      end
      step();
    end
  endtask

  task automatic test_busy_violation();
    for (int n = 0; n <= 7; n++) begin
      bit want_drdy, want_perr;
      want_drdy = (n == 4);
      want_perr = (n >= 3);
      total++;
      if (drdy0 !== want_drdy || perr0 !== want_perr || do0 !== exp_do[0]) begin
        bad++;
        $display("FAIL busy n=%0d got drdy=%b perr=%b do=%h want drdy=%b perr=%b do=%h",
                 n, drdy0, perr0, do0, want_drdy, want_perr, exp_do[0]);
      end
      if (n == 0 || n == 2) begin
        i_den[0] = 1; i_dwe[0] = 0; i_addr[0] = 5'h08; i_di[0] = '0;
      end
      step();
    end
  endtask

  task automatic test_lock();
    int k;
    i_pll[0] = 1;
    for (int n = 0; n < 10; n++) step();
    total++;
    if (locked0 !== 1'b0) begin
      bad++;
      $display("FAIL lock_held got locked=%b want 0", locked0);
    end
    for (int pass = 0; pass < 2; pass++) begin
      i_pll[0] = 0;
      if (pass == 1) begin
        for (int n = 0; n < 40; n++) step();
        i_pll[0] = 1;
        step();
        i_pll[0] = 0;
      end
      k = 0;
      do begin
        step();
        k++;
        total++;
        if (locked0 !== m_locked[0]) begin
          bad++;
          $display("FAIL lock_cyc pass=%0d k=%0d got locked=%b want %b", pass, k, locked0,
                   m_locked[0]);
        end
      end while (!locked0 && k < 200);
      total++;
      if (k != 64) begin
        bad++;
        $display("FAIL lock_rise pass=%0d got %0d cycles want 64", pass, k);
      end
    end
  endtask

  task automatic test_reset_mid();
    i_den[0] = 1; i_dwe[0] = 1; i_addr[0] = 5'h03; i_di[0] = 16'hBEEF;
    step();
    step();
    RST = 1'b1;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      #1;
      total++;
      if ({drdy0, do0, locked0, perr0, drdy1, do1, locked1, perr1} !== '0) begin
        bad++;
        $display("FAIL rst_mid n=%0d got d0=%b/%h/%b/%b d1=%b/%h/%b/%b want all zero", n,
                 drdy0, do0, locked0, perr0, drdy1, do1, locked1, perr1);
      end
      @(negedge CLK);
      cyc++;
    end
    RST = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      bit want_drdy;
      want_drdy = (n == 10);
      total++;
      if (drdy0 !== want_drdy || do0 !== 16'h0000) begin
        bad++;
        $display("FAIL rst_mid_after n=%0d got drdy=%b do=%h want drdy=%b do=0000",
                 n, drdy0, do0, want_drdy);
      end
      if (n == 6) begin
        i_den[0] = 1; i_dwe[0] = 0; i_addr[0] = 5'h03; i_di[0] = '0;
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        i_den[k]  = ($urandom % 100) < 45;
        i_dwe[k]  = $urandom % 2;
        i_addr[k] = 5'($urandom % 8);
        i_di[k]   = 16'($urandom);
        i_pll[k]  = ($urandom % 40) == 0;
      end
      step();
      total++;
      if (drdy0 !== exp_drdy[0] || do0 !== exp_do[0] || perr0 !== m_prot[0] ||
          locked0 !== m_locked[0]) begin
        bad++;
        $display("FAIL rand0 cyc=%0d got %b/%h/%b/%b want %b/%h/%b/%b", cyc, drdy0, do0,
                 perr0, locked0, exp_drdy[0], exp_do[0], m_prot[0], m_locked[0]);
      end
      total++;
      if (drdy1 !== exp_drdy[1] || do1 !== exp_do[1] || perr1 !== m_prot[1] ||
          locked1 !== m_locked[1]) begin
        bad++;
        $display("FAIL rand1 cyc=%0d got %b/%h/%b/%b want %b/%h/%b/%b", cyc, drdy1, do1,
                 perr1, locked1, exp_drdy[1], exp_do[1], m_prot[1], m_locked[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_busy_violation();
    test_lock();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
